// File: rtl/vga_dither_out.sv
// VGA output stage: 8->4 bit per channel with 2x2 ordered dither, delay-matched syncs,
// active-resolution measurement, frame counting and sticky underflow status.
module vga_dither_out #(
  parameter int CNT_W   = 12,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [23:0]        vid_data,
  input  logic               vid_datavalid,
  input  logic               vid_h_sync,
  input  logic               vid_v_sync,
  input  logic               vid_h,
  input  logic               vid_v,
  input  logic               vid_underflow,
  input  logic               dither_en,
  input  logic               clear_status,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [CNT_W-1:0]   meas_width,
  output logic [CNT_W-1:0]   meas_height,
  output logic               meas_valid,
  output logic [FRAME_W-1:0] frame_count,
  output logic               underflow_seen
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

  // Saturating 8->4 bit reduction of one channel with an additive dither offset.
  function automatic logic [3:0] dither_ch(input logic [7:0] c, input logic [3:0] d);
    logic [8:0] s;
    s = {1'b0, c} + {5'b00000, d};
    return s[8] ? 4'hF : s[7:4];
  endfunction

  // Stage-1 registers
  logic [23:0] data_r;
  logic        dv_r;
  logic        blank_r;
  logic        hs_r;
  logic        vs_r;
  logic        v_r;
  logic        den_r;
  logic        x_lsb_r;
  logic        y_lsb_r;

  // Measurement state
  logic [CNT_W-1:0]     pix_cnt_r;
  logic [CNT_W-1:0]     last_w_r;
  logic [CNT_W-1:0]     line_cnt_r;
  logic [2*CNT_W-1:0]   prev_pair_r;

  logic       fall_s;
  logic       frame_end_s;
  logic       frame_ok_s;
  logic       pix_on_s;
  logic [3:0] offset_s;

  // Edge detects and dither offset selection for the pixel held in stage 1.
  always_comb begin
    fall_s      = dv_r & ~vid_datavalid;
    frame_end_s = vid_v & ~v_r;
    frame_ok_s  = frame_end_s & (line_cnt_r != CNT_ZERO);
    // A stray datavalid during horizontal blanking must never reach the DAC.
    pix_on_s    = dv_r & ~blank_r;
    case ({y_lsb_r, x_lsb_r})
      2'b00:   offset_s = 4'd0;
      2'b01:   offset_s = 4'd8;
      2'b10:   offset_s = 4'd12;
      2'b11:   offset_s = 4'd4;
      default: offset_s = 4'd0;
    endcase
    if (!den_r) begin
      offset_s = 4'd0;
    end else begin
      offset_s = offset_s;
    end
  end

  // Stage 1: register the video inputs and track pixel/line parity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r  <= 24'd0;
      dv_r    <= 1'b0;
      blank_r <= 1'b0;
      hs_r    <= 1'b0;
      vs_r    <= 1'b0;
      v_r     <= 1'b0;
      den_r   <= 1'b0;
      x_lsb_r <= 1'b0;
      y_lsb_r <= 1'b0;
    end else begin
      data_r  <= vid_data;
      dv_r    <= vid_datavalid;
      blank_r <= vid_h;
      hs_r    <= vid_h_sync;
      vs_r    <= vid_v_sync;
      v_r     <= vid_v;
      den_r   <= dither_en;
      if (vid_datavalid) begin
        x_lsb_r <= dv_r ? ~x_lsb_r : 1'b0;
      end else begin
        x_lsb_r <= 1'b0;
      end
      if (vid_v) begin
        y_lsb_r <= 1'b0;
      end else if (fall_s) begin
        y_lsb_r <= ~y_lsb_r;
      end else begin
        y_lsb_r <= y_lsb_r;
      end
    end
  end

  // Stage 2: dithered DAC data and delay-matched syncs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r  <= 4'd0;
      vga_g  <= 4'd0;
      vga_b  <= 4'd0;
      vga_hs <= 1'b0;
      vga_vs <= 1'b0;
    end else begin
      vga_hs <= hs_r;
      vga_vs <= vs_r;
      if (pix_on_s) begin
        vga_r <= dither_ch(data_r[23:16], offset_s);
        vga_g <= dither_ch(data_r[15:8], offset_s);
        vga_b <= dither_ch(data_r[7:0], offset_s);
      end else begin
        vga_r <= 4'd0;
        vga_g <= 4'd0;
        vga_b <= 4'd0;
      end
    end
  end

  // Line-width and line-count accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt_r  <= CNT_ZERO;
      last_w_r   <= CNT_ZERO;
      line_cnt_r <= CNT_ZERO;
    end else begin
      if (fall_s) begin
        pix_cnt_r <= CNT_ZERO;
        last_w_r  <= pix_cnt_r;
      end else if (vid_datavalid && (pix_cnt_r != CNT_MAX)) begin
        pix_cnt_r <= pix_cnt_r + CNT_ONE;
      end else begin
        pix_cnt_r <= pix_cnt_r;
      end
      if (frame_end_s) begin
        line_cnt_r <= CNT_ZERO;
      end else if (fall_s && (line_cnt_r != CNT_MAX)) begin
        line_cnt_r <= line_cnt_r + CNT_ONE;
      end else begin
        line_cnt_r <= line_cnt_r;
      end
    end
  end

  // Frame-end capture of the measured resolution and its stability flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meas_width  <= CNT_ZERO;
      meas_height <= CNT_ZERO;
      meas_valid  <= 1'b0;
      prev_pair_r <= {(2*CNT_W){1'b0}};
    end else if (frame_ok_s) begin
      meas_width  <= last_w_r;
      meas_height <= line_cnt_r;
      meas_valid  <= ({last_w_r, line_cnt_r} == prev_pair_r);
      prev_pair_r <= {last_w_r, line_cnt_r};
    end else begin
      meas_width  <= meas_width;
      meas_height <= meas_height;
      meas_valid  <= meas_valid;
      prev_pair_r <= prev_pair_r;
    end
  end

  // Status: frame counter and sticky underflow; a frame end or underflow beats the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count    <= {FRAME_W{1'b0}};
      underflow_seen <= 1'b0;
    end else begin
      if (frame_ok_s) begin
        frame_count <= clear_status ? FRAME_ONE : frame_count + FRAME_ONE;
      end else if (clear_status) begin
        frame_count <= {FRAME_W{1'b0}};
      end else begin
        frame_count <= frame_count;
      end
      if (vid_underflow) begin
        underflow_seen <= 1'b1;
      end else if (clear_status) begin
        underflow_seen <= 1'b0;
      end else begin
        underflow_seen <= underflow_seen;
      end
    end
  end

endmodule

// File: tb/tb_vga_dither_out.sv
// Randomized self-checking bench for vga_dither_out against a behavioural model.
module tb_vga_dither_out;

  localparam int CNT_W   = 12;
  localparam int FRAME_W = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [23:0]        vid_data;
  logic               vid_datavalid, vid_h_sync, vid_v_sync, vid_h, vid_v;
  logic               vid_underflow, dither_en, clear_status;
  logic [3:0]         vga_r, vga_g, vga_b;
  logic               vga_hs, vga_vs;
  logic [CNT_W-1:0]   meas_width, meas_height;
  logic               meas_valid;
  logic [FRAME_W-1:0] frame_count;
  logic               underflow_seen;

  vga_dither_out #(.CNT_W(CNT_W), .FRAME_W(FRAME_W)) dut (
    .clk(clk), .reset(reset), .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .vid_h(vid_h), .vid_v(vid_v),
    .vid_underflow(vid_underflow), .dither_en(dither_en), .clear_status(clear_status),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .meas_width(meas_width), .meas_height(meas_height), .meas_valid(meas_valid),
    .frame_count(frame_count), .underflow_seen(underflow_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: pixel position in the current datavalid run, lines since vblank,
  // expected pixel/sync outputs in flight, and the measurement history.
  int          run_x, line_y;
  logic        prev_dv;
  logic [13:0] exp_q[$];
  int          prev_w, prev_h, exp_fc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dither_offset(input int x, input int y);
    int idx;
    idx = (y % 2) * 2 + (x % 2);
    case (idx)
      0: return 0;
      1: return 8;
      2: return 12;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] ref_ch(input int c, input int d);
    int s;
    s = c + d;
    if (s > 255) return 4'hF;
    return 4'(s / 16);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(14'd0);
    run_x = 0; line_y = 0; prev_dv = 1'b0;
    prev_w = 0; prev_h = 0; exp_fc = 0;
  endtask

  task automatic step(input logic [23:0] d, input logic dv, input logic hs, input logic vs,
                      input logic v, input logic den, input logic uf, input logic clr);
    int off;
    logic [13:0] e;
    vid_data = d; vid_datavalid = dv; vid_h = ~dv; vid_h_sync = hs; vid_v_sync = vs;
    vid_v = v; dither_en = den; vid_underflow = uf; clear_status = clr;
    if (v) line_y = 0;
    else if (prev_dv && !dv) line_y++;
    if (dv) run_x = prev_dv ? run_x + 1 : 0;
    off = den ? dither_offset(run_x, line_y) : 0;
    e = 14'd0;
    if (dv) e[13:2] = {ref_ch(int'(d[23:16]), off), ref_ch(int'(d[15:8]), off),
                       ref_ch(int'(d[7:0]), off)};
    e[1] = hs; e[0] = vs;
    prev_dv = dv;
    exp_q.push_back(e);
    @(posedge clk); #1;
    check_eq("pix_sync", {vga_r, vga_g, vga_b, vga_hs, vga_vs}, exp_q.pop_front());
  endtask

  task automatic check_meas(input int w, input int h);
    logic vld;
    vld = (w == prev_w) && (h == prev_h);
    prev_w = w; prev_h = h;
    check_eq("meas_width", meas_width, w);
    check_eq("meas_height", meas_height, h);
    check_eq("meas_valid", meas_valid, vld);
    check_eq("frame_count", frame_count, exp_fc);
  endtask

  task automatic frame(input int w, input int h, input logic den, input logic [23:0] pix,
                       input bit rnd, input bit clr_end);
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) step(rnd ? 24'($urandom) : pix, 1'b1, 1'b0, 1'b0, 1'b0, den, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) step(24'd0, 1'b0, (k < 2), 1'b0, 1'b0, den, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) step(24'd0, 1'b0, 1'b0, 1'b1, 1'b1, den, 1'b0, (clr_end && k == 0));
    exp_fc = clr_end ? 1 : exp_fc + 1;
    check_meas(w, h);
  endtask

  initial begin
    reset = 1'b1;
    vid_data = 24'd0; vid_datavalid = 1'b0; vid_h = 1'b1; vid_h_sync = 1'b0; vid_v_sync = 1'b0;
    vid_v = 1'b0; vid_underflow = 1'b0; dither_en = 1'b0; clear_status = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {vga_r, vga_g, vga_b, vga_hs, vga_vs, meas_width, meas_height,
                               meas_valid, frame_count, underflow_seen}, 64'd0);
    reset = 1'b0;
    model_reset();

    // Resolution measurement: three identical frames, then a different size.
    frame(64, 48, 1'b0, 24'd0, 1'b1, 1'b0);
    frame(64, 48, 1'b1, 24'd0, 1'b1, 1'b0);
    frame(64, 48, 1'b1, 24'd0, 1'b1, 1'b0);
    frame(80, 60, 1'b0, 24'd0, 1'b1, 1'b0);
    check_eq("fc_after_4", frame_count, 4);

    // Plain truncation, then blanking forces black; closed off as a 1x1 frame.
    step(24'hA53CFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("trunc_pixel", {vga_r, vga_g, vga_b}, 12'hA3F);
    step(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("trunc_blank", {vga_r, vga_g, vga_b}, 12'h000);
    for (int k = 0; k < 3; k++) step(24'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_fc++;
    check_meas(1, 1);

    // Dither pattern on a flat mid-grey block and saturation on full white.
    frame(4, 4, 1'b1, 24'h787878, 1'b0, 1'b0);
    frame(4, 4, 1'b1, 24'hFFFFFF, 1'b0, 1'b0);

    // Sticky underflow and clear priority.
    step(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("uf_set", underflow_seen, 1'b1);
    frame(8, 2, 1'b1, 24'd0, 1'b1, 1'b0);
    frame(8, 2, 1'b1, 24'd0, 1'b1, 1'b0);
    check_eq("uf_hold", underflow_seen, 1'b1);
    step(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("uf_cleared", underflow_seen, 1'b0);
    check_eq("fc_cleared", frame_count, 0);
    exp_fc = 0;
    step(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("uf_set_wins", underflow_seen, 1'b1);
    frame(8, 2, 1'b1, 24'd0, 1'b1, 1'b0);
    frame(8, 2, 1'b1, 24'd0, 1'b1, 1'b1);
    check_eq("fc_clear_at_end", frame_count, 1);

    // Random pixels, syncs and dither enable.
    for (int i = 0; i < 1000; i++)
      step(24'($urandom), ($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(15, 0) == 0), 1'($urandom), 1'b0, 1'b0);

    // Asynchronous reset in the middle of a line.
    for (int p = 0; p < 320; p++) begin
      step(24'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (p == 300) break;
    end
    #2 reset = 1'b1;
    #1;
    check_eq("async_reset", {vga_r, vga_g, vga_b, vga_hs, vga_vs, meas_width, meas_height,
                             meas_valid, frame_count, underflow_seen}, 64'd0);
    vid_datavalid = 1'b0; vid_h = 1'b1; vid_v = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    frame(32, 6, 1'b1, 24'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_dither_out.md
# vga_dither_out

Output stage that sits directly downstream of the clocked-video interface (alt_vip_itc) on the DE10-Lite D8M video path. It consumes the 24-bit RGB clocked-video stream and drives the board's 4-bit-per-channel VGA DAC. Each channel is reduced from 8 to 4 bits with 2x2 ordered dithering, and the syncs are delay-matched to the pixels. It also measures the active resolution, counts frames, and latches underflow for Nios/LED status.

## Interface
Parameters:
- CNT_W, 12, width of pixel and line counters and of the measurement outputs
- FRAME_W, 16, width of the frame counter

Ports:
- clk  in  1  video pixel clock, the same clock as the clocked-video vid_clk; the only clock
- reset  in  1  asynchronous, active-high reset
- vid_data  in  24  pixel data: R=[23:16], G=[15:8], B=[7:0]
- vid_datavalid  in  1  active-pixel qualifier
- vid_h_sync, vid_v_sync  in  1  syncs; passed through with their polarity unchanged
- vid_h, vid_v  in  1  horizontal and vertical blanking flags, high while blanking
- vid_underflow  in  1  underflow flag from the clocked-video source
- dither_en  in  1  1 = ordered dither, 0 = plain truncation; quasi-static (switch input)
- clear_status  in  1  single-cycle pulse; clears underflow_seen and frame_count
- vga_r, vga_g, vga_b  out  4  DAC data
- vga_hs, vga_vs  out  1  delay-matched syncs
- meas_width, meas_height  out  CNT_W  last measured active width and height
- meas_valid  out  1  the last two frames measured identically
- frame_count  out  FRAME_W  number of completed frames; wraps at the top of its range
- underflow_seen  out  1  sticky underflow flag

## Operation
- Stage 1 registers all video inputs and tracks pixel coordinates:
  - x increments on each datavalid cycle and clears when datavalid is low.
  - y clears while vid_v=1 and increments on each falling edge of datavalid.
- Stage 2 produces the pixel outputs:
  - Dither offset d comes from (y[0], x[0]): (0,0)=0, (0,1)=8, (1,0)=12, (1,1)=4.
  - Per channel, with c the 8-bit input: s = c + (dither_en ? d : 0) as a 9-bit sum; output = s[8] ? 4'hF : s[7:4]. The output therefore saturates and never wraps.
  - When the stage-1 datavalid is 0, vga_r, vga_g and vga_b are 0.
- Resolution measurement:
  - pix_cnt counts datavalid cycles and saturates at 2^CNT_W-1.
  - On a datavalid falling edge: last_w <= pix_cnt, line_cnt increments (saturating), pix_cnt clears.
  - On a vid_v rising edge (frame end):
    - If line_cnt>0: meas_width <= last_w and meas_height <= line_cnt. meas_valid <= 1 if (last_w, line_cnt) equals the previous frame's pair, else 0. frame_count increments.
    - If line_cnt=0: the edge is ignored and nothing is updated.
    - In either case line_cnt clears.
- underflow_seen:
  - Set on any cycle with vid_underflow=1.
  - clear_status clears it. If set and clear occur in the same cycle, set wins.
  - clear_status also zeroes frame_count. If a frame end occurs in the same cycle, frame_count becomes 1.

## Timing
- Reset (asynchronous): every output is 0, and all counters, pipeline registers and the previous-frame pair are 0.
- Pixel latency is exactly 2 clk cycles from vid_data/vid_datavalid to vga_r/g/b.
- vga_hs and vga_vs are vid_h_sync/vid_v_sync delayed by exactly 2 cycles, keeping edge alignment with the pixels.
- Measurement outputs update 1 cycle after the cycle in which vid_v is first seen high (a registered edge detect). They are held until the next valid frame end.
- underflow_seen rises 1 cycle after vid_underflow.
- The block has no backpressure; it accepts one pixel every cycle.
- A reset mid-frame discards the partial frame. The first frame end after reset can never set meas_valid unless the frame is 0x0, which is ignored anyway.
- dither_en changes take effect 2 cycles later; a mid-frame change is allowed.

## Test plan
- **Truncation path.** dither_en=0, pixel 0xA5_3C_FF → 2 cycles later vga = (A, 3, F); during blanking vga = (0, 0, 0).
- **Dither pattern.** dither_en=1, constant pixel 0x78_78_78 over a 4x4 block → outputs 7, 8, 7, 8 on even rows and 8, 7, 8, 7 on odd rows. Pixel 0xFF_FF_FF → 0xF everywhere with no wrap.
- **Sync alignment.** Random h/v sync pattern → vga_hs/vs equal the inputs delayed by 2 cycles, bit-exact over 1000 cycles.
- **Resolution measurement.** Three 640x480 frames then one 800x600 frame:
  - After frame 1: meas_width=640, meas_height=480, meas_valid=0.
  - After frames 2 and 3: meas_valid=1.
  - After the 800x600 frame: meas_width=800, meas_height=600, meas_valid=0.
  - frame_count=4.
- **Sticky status and priority.**
  - A single-cycle underflow sets underflow_seen, which holds through 2 frames.
  - clear_status alone clears underflow_seen and sets frame_count=0.
  - clear_status coincident with underflow leaves underflow_seen=1.
  - clear_status coincident with a frame end leaves frame_count=1.
- **Reset mid-line.** Assert reset at x=300 → all outputs 0 asynchronously. After release, the next complete frame reports the correct size with meas_valid=0.
